// File: rtl/alu_if.sv
// Handshake bundle between the decode stage, alu_pipe and the writeback register.
// The slave modport is the ALU's view; master is the upstream/downstream side.
interface alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             op_mul;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             ov;

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, op_mul, out_ready,
        output in_ready, out_valid, out, zr, ng, ov
    );

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, op_mul, out_ready,
        input  in_ready, out_valid, out, zr, ng, ov
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered Hack-style ALU with valid/ready handshake, signed-overflow flag and an
// optional WIDTH-cycle shift-add multiplier.
module alu_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned MUL_EN = 1
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic             no_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             zr_q, ng_q, ov_q;

    logic             op_mul_eff;
    logic             in_ready;
    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] xa, ya, r, alu_out, prod, mul_out;
    logic             alu_ov;

    assign op_mul_eff = (MUL_EN != 0) ? bus.op_mul : 1'b0;

    always_comb begin
        xa = bus.zx ? '0 : bus.x;
        xa = bus.nx ? ~xa : xa;
        ya = bus.zy ? '0 : bus.y;
        ya = bus.ny ? ~ya : ya;
        r = bus.f ? (xa + ya) : (xa & ya);
        alu_out = bus.no ? ~r : r;
        alu_ov = bus.f && (xa[WIDTH-1] == ya[WIDTH-1]) && (r[WIDTH-1] != xa[WIDTH-1]);
        // One partial product per cycle: add the shifted multiplicand when the multiplier LSB is set.
        prod = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_out = no_q ? ~prod : prod;
    end

    always_comb begin
        state_d = state_q;
        in_ready = !reset && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
        accept = bus.in_valid && in_ready;
        mul_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && op_mul_eff) begin
                    state_d = StMul;
                end
            end
            StMul: begin
                if (cnt_q == CntLast) begin
                    mul_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q <= '0;
            acc_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            no_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_q <= '0;
            zr_q <= 1'b0;
            ng_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !op_mul_eff) begin
                out_valid_q <= 1'b1;
                out_q <= alu_out;
                zr_q <= (alu_out == '0);
                ng_q <= alu_out[WIDTH-1];
                ov_q <= alu_ov;
            end else if (mul_done) begin
                out_valid_q <= 1'b1;
                out_q <= mul_out;
                zr_q <= (mul_out == '0);
                ng_q <= mul_out[WIDTH-1];
                ov_q <= 1'b0;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept && op_mul_eff) begin
                acc_q <= '0;
                mcand_q <= xa;
                mplier_q <= ya;
                no_q <= bus.no;
                cnt_q <= '0;
            end else if (state_q == StMul) begin
                acc_q <= prod;
                mcand_q <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out = out_q;
    assign bus.zr = zr_q;
    assign bus.ng = ng_q;
    assign bus.ov = ov_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed handshake/reset scenarios plus random
// operations compared against an arithmetic reference model.
module tb_alu_pipe;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ctl = {zx,nx,zy,ny,f,no}; returns {ov, out}
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] ctl, input logic mul);
        logic [15:0] xa, ya, r;
        logic [31:0] p;
        int          s;
        logic        ov;
        xa = ctl[5] ? 16'h0 : x;
        if (ctl[4]) xa = ~xa;
        ya = ctl[3] ? 16'h0 : y;
        if (ctl[2]) ya = ~ya;
        ov = 1'b0;
        if (mul) begin
            p = 32'(xa) * 32'(ya);
            r = p[15:0];
        end else if (ctl[1]) begin
            r = xa + ya;
            s = int'($signed(xa)) + int'($signed(ya));
            ov = (s > 32767) || (s < -32768);
        end else begin
            r = xa & ya;
        end
        if (ctl[0]) r = ~r;
        return {ov, r};
    endfunction

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [5:0] ctl,
                         input logic mul);
        bus.x = x;
        bus.y = y;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctl;
        bus.op_mul = mul;
    endtask

    task automatic chk_result(input string tag, input logic [16:0] e);
        chk({tag, "_out"}, 32'(bus.out), 32'(e[15:0]));
        chk({tag, "_zr"}, 32'(bus.zr), 32'(e[15:0] == 16'h0));
        chk({tag, "_ng"}, 32'(bus.ng), 32'(e[15]));
        chk({tag, "_ov"}, 32'(bus.ov), 32'(e[16]));
    endtask

    // Called at a negedge; returns at the negedge where the result is first visible.
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [5:0] ctl, input logic mul);
        logic [16:0] e;
        int          n;
        int          lat;
        int          low;
        e = model(x, y, ctl, mul);
        drive(x, y, ctl, mul);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        low = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && !bus.in_ready) low++;
        end while (!bus.out_valid && lat < 40);
        chk({tag, "_latency"}, 32'(lat), mul ? 32'(W + 1) : 32'd1);
        if (mul) chk({tag, "_busy"}, 32'(low), 32'(W));
        chk_result(tag, e);
    endtask

    initial begin
        int stray;
        logic [5:0] rc;
        logic       rm;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(16'h0, 16'h0, 6'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_flags", 32'({bus.zr, bus.ng, bus.ov}), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back single-cycle ops
        drive(16'h1248, 16'h137F, 6'b111111, 1'b0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("b2b1_valid", 32'(bus.out_valid), 32'd1);
        chk_result("b2b1", {1'b0, 16'h0001});
        chk("b2b1_ready", 32'(bus.in_ready), 32'd1);
        drive(16'hFFFF, 16'h0000, 6'b000000, 1'b0);
        @(negedge clk);
        chk("b2b2_valid", 32'(bus.out_valid), 32'd1);
        chk_result("b2b2", {1'b0, 16'h0000});
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        run_op("add_ov", 16'h7FFF, 16'h0001, 6'b000010, 1'b0);
        chk("add_ov_exp", 32'({bus.ov, bus.out}), 32'h18000);
        run_op("nx_no", 16'h002A, 16'h0081, 6'b010011, 1'b0);
        chk("nx_no_exp", 32'(bus.out), 32'hFFA9);
        run_op("mul_neg", 16'h0007, 16'hFFFD, 6'b000000, 1'b1);
        chk("mul_neg_exp", 32'(bus.out), 32'hFFEB);
        run_op("mul_zero", 16'h0100, 16'h0100, 6'b000000, 1'b1);

        // Backpressure: result held while out_ready is low
        @(negedge clk);
        drive(16'h1248, 16'h137F, 6'b111111, 1'b0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(16'h7FFF, 16'h0001, 6'b000010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_out", 32'({bus.out_valid, bus.out}), 32'h10001);
            chk("hold_flags", 32'({bus.zr, bus.ng, bus.ov}), 32'd0);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("release_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("release_valid", 32'(bus.out_valid), 32'd1);
        chk_result("release", {1'b1, 16'h8000});

        // Reset in the middle of a multiply
        @(negedge clk);
        drive(16'h0007, 16'hFFFD, 6'b000000, 1'b1);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out", 32'(bus.out), 32'd0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        chk("midrst_stray", 32'(stray), 32'd0);
        run_op("post_rst", 16'h0003, 16'h0004, 6'b000010, 1'b0);
        chk("post_rst_exp", 32'(bus.out), 32'h0007);

        // Reset held with a bundle offered
        @(negedge clk);
        reset = 1'b1;
        drive(16'h1111, 16'h2222, 6'b000010, 1'b0);
        bus.in_valid = 1'b1;
        #1 chk("hold_rst_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rst_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_rst_outs", 32'({bus.out_valid, bus.out, bus.zr, bus.ng, bus.ov}), 32'd0);
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            rc = 6'($urandom);
            rm = ($urandom_range(0, 3) == 0);
            run_op("rand", 16'($urandom), 16'($urandom), rc, rm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
